pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline sequencer for the 5-stage RV32I core. It consumes the EX-stage branch decision, jump resolution, load-use and shared-memory-port conditions, and ID-stage halt requests. It drives PC write-enable and select, IF/ID hold and flush, ID/EX bubble insertion, and a halt-drain state machine. It also keeps saturating redirect and stall counters for performance debug.

## Interface
- `DRAIN_CYCLES`, 3: cycles spent draining after a halt instruction leaves ID, before `halted` asserts; legal range 1..15.
- `CNT_W`, 16: width of each performance counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `branch_taken`  in  1  EX-stage conditional-branch decision is taken.
- `jump`  in  1  EX-stage JAL/JALR.
- `id_ex_mem_read`  in  1  instruction in EX is a load.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `if_id_rs1`  in  5  rs1 of the instruction in ID.
- `if_id_rs2`  in  5  rs2 of the instruction in ID.
- `if_id_use_rs2`  in  1  instruction in ID reads rs2.
- `mem_port_busy`  in  1  the MEM stage uses the single shared memory port this cycle.
- `halt_req`  in  1  instruction in ID is ECALL/EBREAK.
- `pc_write`  out  1  PC register load enable.
- `pc_sel`  out  1  0 = PC+4; 1 = EX redirect target.
- `if_id_write`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_ex_flush`  out  1  load a bubble (all control zero) into ID/EX.
- `halted`  out  1  core has stopped.
- `redirect_cnt`  out  CNT_W  number of redirect cycles.
- `stall_cnt`  out  CNT_W  number of load-use and memory-port stall cycles.

## Operation
- State register `st` has three states: RUN, DRAIN, HALTED. The drain counter `dcnt` is 4 bits wide.
- While `rst` is low:
  - all outputs are 0.
  - `st` = RUN, `dcnt` = 0, both counters = 0.
- Outputs are combinational from `st` and the current inputs. Default (RUN, no event): `pc_write`=1, `if_id_write`=1, all other outputs 0.
- `lu` = `id_ex_mem_read` & (`id_ex_rd`≠0) & ((`id_ex_rd`==`if_id_rs1`) | (`if_id_use_rs2` & `id_ex_rd`==`if_id_rs2`)).
- RUN priority, highest first:
  1. Redirect (`branch_taken` | `jump`):
     - `pc_sel`=1, `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=1.
     - `lu`, `mem_port_busy` and `halt_req` are ignored, because the ID instruction is on the wrong path.
     - `redirect_cnt` increments.
  2. `lu`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; `stall_cnt` increments.
  3. `mem_port_busy` (no fetch possible): `pc_write`=0, `if_id_write`=1, `if_id_flush`=1; `stall_cnt` increments.
  4. `halt_req`:
     - `pc_write`=0, `if_id_flush`=1. The halt instruction itself proceeds into ID/EX.
     - Next state is DRAIN with `dcnt` = `DRAIN_CYCLES`.
- If `halt_req` coincides with `lu` or `mem_port_busy`, the stall wins and the halt is taken on a later cycle when no stall is active.
- DRAIN:
  - `pc_write`=0, `if_id_write`=1, `if_id_flush`=1.
  - `dcnt` decrements every cycle; when `dcnt`==1, next state is HALTED.
  - All hazard inputs are ignored. No older branch can resolve after the halt instruction leaves ID.
- HALTED:
  - `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_flush`=1, `halted`=1.
  - HALTED is left only by reset.
- Counters saturate at all-ones and never wrap. Both counters are cleared only by reset.

## Timing
- Decision-to-control latency is 0 cycles. Outputs act in the same cycle as the inputs, and the pipeline registers capture on the next edge.
- The taken-branch penalty is exactly 2 squashed instructions (IF and ID), with one redirect cycle.
- A load-use stall lasts exactly 1 cycle per hazard. On the next cycle the load has moved to MEM, so `lu` drops without further state.
- `halt_req` accepted at edge N (in RUN) gives: DRAIN during cycles N+1..N+`DRAIN_CYCLES`, and `halted`=1 from cycle N+`DRAIN_CYCLES`+1.
- Asynchronous reset mid-DRAIN or in HALTED forces RUN immediately, without waiting for a clock edge.
- The first cycle after reset release has default RUN outputs.

## Test plan
- Branch taken: `branch_taken`=1 for one cycle in RUN, with `lu`=1 at the same time → `pc_sel`=1, `pc_write`=1, both flushes 1, `stall_cnt` unchanged, `redirect_cnt` 0→1.
- Load-use: `id_ex_mem_read`=1, `id_ex_rd`=5, `if_id_rs2`=5, `if_id_use_rs2`=1 → `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `stall_cnt`+1. Repeat with `id_ex_rd`=0 → no stall.
- Halt: `halt_req`=1 with `DRAIN_CYCLES`=3 → 3 DRAIN cycles with `pc_write`=0, then `halted`=1 from the 4th cycle onward. Asserting `branch_taken` while in HALTED → no change.
- Halt cancelled by jump: `halt_req`=1 together with `jump`=1 → redirect outputs, state stays RUN, `halted` never asserts.
- Counter saturation: `CNT_W`=4, 20 consecutive `mem_port_busy` cycles → `stall_cnt`=15, no wrap.
- Reset in DRAIN: drop `rst` in the 2nd DRAIN cycle, between clock edges → all outputs 0 immediately. After release: RUN defaults, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard sequencer for the 5-stage RV32I core. It turns the EX redirect,
// load-use, shared-memory-port and ID halt conditions into PC and pipeline-register
// controls. A small FSM drains the pipe after a halt. Two saturating counters
// record redirect and stall cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal issue; redirect > load-use > mem port > halt priority
// DRAIN  | halt left ID; flushing fetch for DRAIN_CYCLES cycles
// HALTED | core stopped; left only by reset
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs2,
    input  logic             mem_port_busy,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } st_t;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    st_t        st;
    st_t        st_nxt;
    logic [3:0] dcnt;
    logic [3:0] dcnt_nxt;
    logic       lu;
    logic       redirect;
    logic       stall;
    logic       redirect_inc;
    logic       stall_inc;

    assign lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));
    assign redirect = branch_taken | jump;
    assign stall    = lu | mem_port_busy;

    // Redirect on a wrong-path halt or stall always wins, so only the top event counts.
    assign redirect_inc = (st == RUN) && redirect;
    assign stall_inc    = (st == RUN) && !redirect && stall;

    // State register and drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= RUN;
            dcnt <= 4'd0;
        end else begin
            st   <= st_nxt;
            dcnt <= dcnt_nxt;
        end
    end

    // Next-state: a halt is accepted only in a RUN cycle with no redirect or stall.
    always_comb begin
        st_nxt   = st;
        dcnt_nxt = dcnt;
        case (st)
            RUN: begin
                if (!redirect && !stall && halt_req) begin
                    st_nxt   = DRAIN;
                    dcnt_nxt = DRAIN_INIT;
                end
            end
            DRAIN: begin
                dcnt_nxt = dcnt - 4'd1;
                if (dcnt == 4'd1) begin
                    st_nxt = HALTED;
                end
            end
            HALTED: begin
                st_nxt = HALTED;
            end
            default: begin
                st_nxt   = RUN;
                dcnt_nxt = 4'd0;
            end
        endcase
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            case (st)
                RUN: begin
                    if (redirect) begin
                        pc_sel      = 1'b1;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (lu) begin
                        id_ex_flush = 1'b1;
                    end else if (mem_port_busy || halt_req) begin
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end
                HALTED: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redirect_inc && (redirect_cnt != CNT_MAX)) begin
                redirect_cnt <= redirect_cnt + 1'b1;
            end
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized episodes checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_taken, jump, id_ex_mem_read, if_id_use_rs2, mem_port_busy, halt_req;
    logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;

    logic        a_pcw, a_pcs, a_ifw, a_iff, a_exf, a_hlt;
    logic [15:0] a_rcnt, a_scnt;
    logic        b_pcw, b_pcs, b_ifw, b_iff, b_exf, b_hlt;
    logic [3:0]  b_rcnt, b_scnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .if_id_use_rs2(if_id_use_rs2), .mem_port_busy(mem_port_busy),
        .halt_req(halt_req), .pc_write(a_pcw), .pc_sel(a_pcs), .if_id_write(a_ifw),
        .if_id_flush(a_iff), .id_ex_flush(a_exf), .halted(a_hlt),
        .redirect_cnt(a_rcnt), .stall_cnt(a_scnt));

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .if_id_use_rs2(if_id_use_rs2), .mem_port_busy(mem_port_busy),
        .halt_req(halt_req), .pc_write(b_pcw), .pc_sel(b_pcs), .if_id_write(b_ifw),
        .if_id_flush(b_iff), .id_ex_flush(b_exf), .halted(b_hlt),
        .redirect_cnt(b_rcnt), .stall_cnt(b_scnt));

    // ---------------- behavioural model ----------------
    // since_halt: -1 while no halt accepted, else number of edges since acceptance (1 = first drain cycle).
    int since_halt = -1;
    int n_red      = 0;
    int n_stall    = 0;

    function automatic bit m_lu();
        return id_ex_mem_read && (id_ex_rd != 0) &&
               ((id_ex_rd == if_id_rs1) || (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));
    endfunction

    // 0 = running, 1 = draining, 2 = halted
    function automatic int m_mode();
        if (since_halt < 0) return 0;
        if (since_halt <= D) return 1;
        return 2;
    endfunction

    // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, halted}
    function automatic logic [5:0] m_ctrl();
        if (!rst) return 6'b000000;
        case (m_mode())
            2: return 6'b000111;
            1: return 6'b001100;
            default: begin
                if (branch_taken || jump) return 6'b111110;
                if (m_lu())               return 6'b000010;
                if (mem_port_busy)        return 6'b001100;
                if (halt_req)             return 6'b001100;
                return 6'b101000;
            end
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            since_halt = -1;
            n_red      = 0;
            n_stall    = 0;
        end else if (m_mode() == 0) begin
            if (branch_taken || jump)           n_red++;
            else if (m_lu() || mem_port_busy)   n_stall++;
            else if (halt_req)                  since_halt = 1;
        end else begin
            since_halt++;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("ctrl16", int'({a_pcw, a_pcs, a_ifw, a_iff, a_exf, a_hlt}), int'(m_ctrl()));
        cmp("redir16", int'(a_rcnt), sat(n_red, 65535));
        cmp("stall16", int'(a_scnt), sat(n_stall, 65535));
        cmp("ctrl4", int'({b_pcw, b_pcs, b_ifw, b_iff, b_exf, b_hlt}), int'(m_ctrl()));
        cmp("redir4", int'(b_rcnt), sat(n_red, 15));
        cmp("stall4", int'(b_scnt), sat(n_stall, 15));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        branch_taken = 0; jump = 0; id_ex_mem_read = 0; if_id_use_rs2 = 0;
        mem_port_busy = 0; halt_req = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0;
        nxt();
        nxt();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        nxt();
        nxt();
        rst = 1;

        // First cycle after release: RUN defaults.
        mid();
        cmp("rel_pcw", a_pcw, 1); cmp("rel_ifw", a_ifw, 1); cmp("rel_iff", a_iff, 0);
        cmp("rel_hlt", a_hlt, 0); cmp("rel_rcnt", a_rcnt, 0);
        nxt();

        // Branch taken with a simultaneous load-use: redirect wins.
        branch_taken = 1; id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs1 = 5;
        mid();
        cmp("br_pcs", a_pcs, 1); cmp("br_pcw", a_pcw, 1);
        cmp("br_iff", a_iff, 1); cmp("br_exf", a_exf, 1);
        nxt(); idle(); mid();
        cmp("br_rcnt", a_rcnt, 1); cmp("br_scnt", a_scnt, 0);
        nxt();

        // Load-use through rs2.
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs1 = 1; if_id_rs2 = 5; if_id_use_rs2 = 1;
        mid();
        cmp("lu_pcw", a_pcw, 0); cmp("lu_ifw", a_ifw, 0); cmp("lu_exf", a_exf, 1);
        nxt(); idle(); mid();
        cmp("lu_scnt", a_scnt, 1);
        nxt();

        // Load to x0 is never a hazard.
        id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0; if_id_use_rs2 = 1;
        mid();
        cmp("x0_pcw", a_pcw, 1); cmp("x0_exf", a_exf, 0);
        nxt(); idle(); mid();
        cmp("x0_scnt", a_scnt, 1);
        nxt();

        // Halt together with a jump: redirect, no halt.
        halt_req = 1; jump = 1;
        mid();
        cmp("hj_pcs", a_pcs, 1); cmp("hj_exf", a_exf, 1);
        nxt(); idle(); mid();
        cmp("hj_pcw", a_pcw, 1); cmp("hj_hlt", a_hlt, 0); cmp("hj_rcnt", a_rcnt, 2);
        nxt();

        // Halt accepted, 3 drain cycles, then halted; branches ignored.
        halt_req = 1;
        mid();
        cmp("h_pcw", a_pcw, 0); cmp("h_iff", a_iff, 1); cmp("h_ifw", a_ifw, 1);
        nxt(); idle(); branch_taken = 1;
        for (int i = 0; i < D; i++) begin
            mid();
            cmp("dr_pcw", a_pcw, 0); cmp("dr_iff", a_iff, 1); cmp("dr_hlt", a_hlt, 0);
            cmp("dr_pcs", a_pcs, 0);
            nxt();
        end
        for (int i = 0; i < 3; i++) begin
            mid();
            cmp("ht_hlt", a_hlt, 1); cmp("ht_pcw", a_pcw, 0); cmp("ht_ifw", a_ifw, 0);
            cmp("ht_exf", a_exf, 1); cmp("ht_rcnt", a_rcnt, 2);
            nxt();
        end
        idle();

        // Async reset in the second drain cycle.
        do_reset();
        jump = 1; nxt(); idle();
        halt_req = 1; nxt(); halt_req = 0;
        nxt();
        #2 rst = 0;
        #1;
        cmp("ar_ctrl", int'({a_pcw, a_pcs, a_ifw, a_iff, a_exf, a_hlt}), 0);
        cmp("ar_rcnt", a_rcnt, 0);
        @(posedge clk); #1 rst = 1;
        mid();
        cmp("ar_pcw", a_pcw, 1); cmp("ar_ifw", a_ifw, 1); cmp("ar_iff", a_iff, 0);
        nxt();

        // 20 memory-port stalls: 4-bit counter saturates at 15.
        mem_port_busy = 1;
        for (int i = 0; i < 20; i++) nxt();
        idle(); mid();
        cmp("sat4", b_scnt, 15); cmp("sat16", a_scnt, 20);
        nxt();

        // Randomized episodes.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                branch_taken   = ($urandom_range(0, 7) == 0);
                jump           = ($urandom_range(0, 9) == 0);
                id_ex_mem_read = $urandom_range(0, 1);
                id_ex_rd       = 5'($urandom_range(0, 3));
                if_id_rs1      = 5'($urandom_range(0, 3));
                if_id_rs2      = 5'($urandom_range(0, 3));
                if_id_use_rs2  = $urandom_range(0, 1);
                mem_port_busy  = ($urandom_range(0, 5) == 0);
                halt_req       = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    #2 rst = 0;
                    @(posedge clk); #1 rst = 1;
                end else begin
                    nxt();
                end
            end
        end

        idle();
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
